// File: rtl/dwt_pkg.sv
// Shared definitions for the 2-D inverse Haar pipeline.
// Holds default widths, default frame geometry in blocks, and the unsigned
// saturation helper used on the final pixel values.
package dwt_pkg;

  localparam int unsigned DEF_CW     = 11;           // signed coefficient width
  localparam int unsigned DEF_PW     = 8;            // unsigned pixel width
  localparam int unsigned DEF_SW     = DEF_CW + 2;   // stage-2 sum width
  localparam int unsigned DEF_WIDTH  = 20;
  localparam int unsigned DEF_HEIGHT = 30;
  localparam int unsigned BLK_W      = DEF_WIDTH / 2;
  localparam int unsigned BLK_H      = DEF_HEIGHT / 2;

  // Widest pixel the helper can produce.
  localparam int unsigned SAT_MAX_PW = 16;

  typedef struct packed {
    logic                  clamp;
    logic [SAT_MAX_PW-1:0] pix;
  } sat_res_t;

  // Clamp a signed value into [0, 2^pw-1]; clamp is set when the value was
  // out of range.
  function automatic sat_res_t sat_u(input logic signed [31:0] val, input int unsigned pw);
    sat_res_t          res;
    logic signed [31:0] max_v;
    max_v = (32'sd1 <<< pw) - 32'sd1;
    res   = '0;
    if (val < 32'sd0) begin
      res.clamp = 1'b1;
    end else if (val > max_v) begin
      res.clamp = 1'b1;
      res.pix   = max_v[SAT_MAX_PW-1:0];
    end else begin
      res.pix = val[SAT_MAX_PW-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/haar_butterfly.sv
// Combinational Haar butterfly: sum_o = x_i + y_i, diff_o = x_i - y_i.
// Ports: x_i, y_i  signed N-bit operands
//        sum_o, diff_o  signed N+1-bit results (never overflow)
module haar_butterfly #(
  parameter int unsigned N = 11
) (
  input  logic signed [N-1:0] x_i,
  input  logic signed [N-1:0] y_i,
  output logic signed [N:0]   sum_o,
  output logic signed [N:0]   diff_o
);

  logic signed [N:0] x_ext;
  logic signed [N:0] y_ext;

  assign x_ext  = {x_i[N-1], x_i};
  assign y_ext  = {y_i[N-1], y_i};
  assign sum_o  = x_ext + y_ext;
  assign diff_o = x_ext - y_ext;

endmodule

// File: rtl/dwt_haar_inv2d_pipe.sv
// Two-stage pipelined 2-D inverse Haar: one coefficient quad per channel in,
// one reconstructed 2x2 pixel block out per cycle, with valid/ready flow
// control, optional rounding/saturation, block coordinates and frame done.
// Ports:
//   HCLK, HRESET           clock, asynchronous active-high reset
//   in_valid/in_ready      coefficient handshake; cA/cH/cV/cD packed per channel
//   out_valid/out_ready    pixel block handshake; p00/p01/p10/p11 packed per channel
//   blk_x, blk_y           block coordinates of the block currently presented
//   frame_done             one-cycle pulse after the last block of a frame
//   sat_flag               sticky per-frame clamp indicator
module dwt_haar_inv2d_pipe
  import dwt_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT,
  parameter int unsigned CH     = 3,
  parameter int unsigned CW     = DEF_CW,
  parameter int unsigned PW     = DEF_PW,
  parameter int unsigned ROUND  = 0,
  parameter int unsigned SAT_EN = 1
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CH*CW-1:0]              cA,
  input  logic [CH*CW-1:0]              cH,
  input  logic [CH*CW-1:0]              cV,
  input  logic [CH*CW-1:0]              cD,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CH*PW-1:0]              p00,
  output logic [CH*PW-1:0]              p01,
  output logic [CH*PW-1:0]              p10,
  output logic [CH*PW-1:0]              p11,
  output logic [$clog2(WIDTH/2)-1:0]    blk_x,
  output logic [$clog2(HEIGHT/2)-1:0]   blk_y,
  output logic                          frame_done,
  output logic                          sat_flag
);

  localparam int unsigned SW      = CW + 2;
  localparam int unsigned NumBlkX = WIDTH / 2;
  localparam int unsigned NumBlkY = HEIGHT / 2;
  localparam int unsigned XW      = $clog2(NumBlkX);
  localparam int unsigned YW      = $clog2(NumBlkY);
  localparam logic [SW-1:0] RndAdd = (ROUND != 0) ? SW'(2) : '0;

  logic en, accept, xfer, last_blk;

  logic s1_valid_q, s1_valid_d;
  logic [CH-1:0][CW:0] l0_w, l1_w, h0_w, h1_w;
  logic [CH-1:0][CW:0] l0_q, l1_q, h0_q, h1_q;
  logic [CH-1:0][CW:0] l0_d, l1_d, h0_d, h1_d;

  // Index 0..3 = p00, p01, p10, p11.
  logic [CH-1:0][3:0][SW-1:0] s_w;
  logic [CH-1:0][3:0][PW-1:0] pix_w, pix_q, pix_d;
  logic [CH-1:0][3:0]         clamp_w;
  logic                       blk_clamp_q, blk_clamp_d;

  logic          out_valid_q, out_valid_d;
  logic [XW-1:0] blk_x_q, blk_x_d;
  logic [YW-1:0] blk_y_q, blk_y_d;
  logic          frame_done_q, frame_done_d;
  logic          sat_flag_q, sat_flag_d;

  // Both stages share one enable so the pipe stalls as a whole.
  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;
  assign accept   = in_valid & en;
  assign xfer     = out_valid_q & out_ready;
  assign last_blk = (blk_x_q == XW'(NumBlkX - 1)) && (blk_y_q == YW'(NumBlkY - 1));

  for (genvar c = 0; c < CH; c++) begin : g_ch
    haar_butterfly #(.N(CW)) u_bf_l (
      .x_i   (cA[c*CW +: CW]),
      .y_i   (cH[c*CW +: CW]),
      .sum_o (l0_w[c]),
      .diff_o(l1_w[c])
    );
    haar_butterfly #(.N(CW)) u_bf_h (
      .x_i   (cV[c*CW +: CW]),
      .y_i   (cD[c*CW +: CW]),
      .sum_o (h0_w[c]),
      .diff_o(h1_w[c])
    );
    haar_butterfly #(.N(CW + 1)) u_bf_top (
      .x_i   (l0_q[c]),
      .y_i   (h0_q[c]),
      .sum_o (s_w[c][0]),
      .diff_o(s_w[c][1])
    );
    haar_butterfly #(.N(CW + 1)) u_bf_bot (
      .x_i   (l1_q[c]),
      .y_i   (h1_q[c]),
      .sum_o (s_w[c][2]),
      .diff_o(s_w[c][3])
    );

    for (genvar k = 0; k < 4; k++) begin : g_pix
      logic signed [SW-1:0] rnd_w;
      logic signed [SW-1:0] shf_w;
      sat_res_t             sat_w;

      assign rnd_w = s_w[c][k] + RndAdd;
      assign shf_w = rnd_w >>> 2;
      assign sat_w = sat_u({{(32 - SW){shf_w[SW-1]}}, shf_w}, PW);
      // Without saturation the low bits wrap and no clamp is reported.
      assign pix_w[c][k]   = (SAT_EN != 0) ? sat_w.pix[PW-1:0] : shf_w[PW-1:0];
      assign clamp_w[c][k] = (SAT_EN != 0) && sat_w.clamp;

      if (PW < SAT_MAX_PW) begin : g_unused
        logic unused_sat_hi;
        assign unused_sat_hi = ^sat_w.pix[SAT_MAX_PW-1:PW];
      end
    end

    assign p00[c*PW +: PW] = pix_q[c][0];
    assign p01[c*PW +: PW] = pix_q[c][1];
    assign p10[c*PW +: PW] = pix_q[c][2];
    assign p11[c*PW +: PW] = pix_q[c][3];
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    l0_d = l0_q;
    l1_d = l1_q;
    h0_d = h0_q;
    h1_d = h1_q;
    if (en) begin
      s1_valid_d = accept;
      if (accept) begin
        l0_d = l0_w;
        l1_d = l1_w;
        h0_d = h0_w;
        h1_d = h1_w;
      end
    end

    out_valid_d = out_valid_q;
    pix_d       = pix_q;
    blk_clamp_d = blk_clamp_q;
    if (en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        pix_d       = pix_w;
        blk_clamp_d = |clamp_w;
      end
    end

    blk_x_d = blk_x_q;
    blk_y_d = blk_y_q;
    if (xfer) begin
      if (blk_x_q == XW'(NumBlkX - 1)) begin
        blk_x_d = '0;
        blk_y_d = last_blk ? '0 : blk_y_q + YW'(1);
      end else begin
        blk_x_d = blk_x_q + XW'(1);
      end
    end

    frame_done_d = xfer & last_blk;

    // The last block of a frame clears the flag together with frame_done.
    sat_flag_d = sat_flag_q;
    if (xfer) begin
      sat_flag_d = last_blk ? 1'b0 : (sat_flag_q | blk_clamp_q);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      s1_valid_q   <= 1'b0;
      l0_q         <= '0;
      l1_q         <= '0;
      h0_q         <= '0;
      h1_q         <= '0;
      out_valid_q  <= 1'b0;
      pix_q        <= '0;
      blk_clamp_q  <= 1'b0;
      blk_x_q      <= '0;
      blk_y_q      <= '0;
      frame_done_q <= 1'b0;
      sat_flag_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      l0_q         <= l0_d;
      l1_q         <= l1_d;
      h0_q         <= h0_d;
      h1_q         <= h1_d;
      out_valid_q  <= out_valid_d;
      pix_q        <= pix_d;
      blk_clamp_q  <= blk_clamp_d;
      blk_x_q      <= blk_x_d;
      blk_y_q      <= blk_y_d;
      frame_done_q <= frame_done_d;
      sat_flag_q   <= sat_flag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign blk_x      = blk_x_q;
  assign blk_y      = blk_y_q;
  assign frame_done = frame_done_q;
  assign sat_flag   = sat_flag_q;

endmodule
